// File: rtl/seq_hit_logger_pkg.sv
// Shared definitions for the sequence hit logger: event type codes,
// LED stretcher state encodings and the event-type helper.
package seq_hit_logger_pkg;

    localparam int EV_TYPE_W = 2;

    localparam logic [1:0] EV_T_NONE = 2'b00;
    localparam logic [1:0] EV_T_0110 = 2'b01;
    localparam logic [1:0] EV_T_1001 = 2'b10;
    localparam logic [1:0] EV_T_BOTH = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Bit 0 marks a 0110 hit, bit 1 a 1001 hit; both set gives EV_T_BOTH.
    function automatic logic [1:0] ev_type(input logic h_0110, input logic h_1001);
        return {h_1001, h_0110};
    endfunction

endpackage

// File: rtl/seq_hit_logger_if.sv
// Event read port of the hit logger. valid/ready: an entry transfers on every
// clock edge where valid and ready are both high; data is stable while valid waits.
interface seq_hit_logger_if #(
    parameter int TS_W  = 8,
    parameter int DEPTH = 8
);
    localparam int EW = 2 + TS_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          valid;
    logic          ready;
    logic [EW-1:0] data;
    logic [CW-1:0] count;

    modport master (output valid, output data, output count, input ready);
    modport slave  (input valid, input data, input count, output ready);

endinterface

// File: rtl/seq_hit_logger_evt_fifo.sv
// Synchronous show-ahead event FIFO: head is always on rd_data, a push into
// a full FIFO without a simultaneous pop is dropped and flagged on drop.
module evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     ready,
    output logic                     valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             pop;
    logic             accept;

    assign full    = (count_q == CW'(DEPTH));
    assign valid   = (count_q != '0);
    assign pop     = valid & ready;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign accept  = push & ~clr & (~full | pop);
    assign drop    = push & ~clr & full & ~pop;
    assign rd_data = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/seq_hit_logger.sv
// Hit logger behind the dual 0110/1001 detector: saturating hit counters,
// LED pulse stretchers and a timestamped event FIFO.
module seq_hit_logger
    import seq_hit_logger_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int TS_W     = 8,
    parameter int DEPTH    = 8,
    parameter int HOLD_CYC = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hit_0110,
    input  logic               hit_1001,
    input  logic               clr,
    output logic [CNT_W-1:0]   cnt_0110,
    output logic [CNT_W-1:0]   cnt_1001,
    output logic               led_0110,
    output logic               led_1001,
    output logic               overflow,
    output logic [1:0]         stretch_state,
    seq_hit_logger_if.master   ev
);
    localparam int EW = EV_TYPE_W + TS_W;
    localparam int RW = $clog2(HOLD_CYC + 1);
    localparam logic [RW-1:0] HOLD_LD = RW'(HOLD_CYC);

    logic [TS_W-1:0] ts;
    logic [1:0]      hits;
    logic            push;
    logic            drop;
    logic [EW-1:0]   wr_data;
    logic [1:0]      st;
    logic [RW-1:0]   rem [2];

    assign hits    = ev_type(hit_0110, hit_1001);
    assign push    = (hits != EV_T_NONE) & ~clr;
    assign wr_data = {hits, ts};

    evt_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .push    (push),
        .wr_data (wr_data),
        .ready   (ev.ready),
        .valid   (ev.valid),
        .rd_data (ev.data),
        .count   (ev.count),
        .drop    (drop)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts       <= '0;
            cnt_0110 <= '0;
            cnt_1001 <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            ts       <= '0;
            cnt_0110 <= '0;
            cnt_1001 <= '0;
            overflow <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (hit_0110 && (cnt_0110 != '1)) cnt_0110 <= cnt_0110 + CNT_W'(1);
            if (hit_1001 && (cnt_1001 != '1)) cnt_1001 <= cnt_1001 + CNT_W'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // One stretcher per pattern; a hit while holding reloads the full length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= '0;
            rem[0] <= '0;
            rem[1] <= '0;
        end else if (clr) begin
            st     <= '0;
            rem[0] <= '0;
            rem[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (st[i])
                    ST_IDLE: begin
                        if (hits[i]) begin
                            st[i]  <= ST_HOLD;
                            rem[i] <= HOLD_LD;
                        end
                    end
                    default: begin
                        if (hits[i]) begin
                            rem[i] <= HOLD_LD;
                        end else if (rem[i] == RW'(1)) begin
                            st[i]  <= ST_IDLE;
                            rem[i] <= '0;
                        end else begin
                            rem[i] <= rem[i] - RW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign led_0110      = (st[0] == ST_HOLD);
    assign led_1001      = (st[1] == ST_HOLD);
    assign stretch_state = st;

endmodule

// File: tb/tb_seq_hit_logger.sv
// Directed bench for seq_hit_logger: a cycle-level reference model with an
// expected-event queue, plus hand-computed spot values for each scenario.
module tb_seq_hit_logger;
    import seq_hit_logger_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       hit_0110;
    logic       hit_1001;
    logic       clr;
    logic [7:0] cnt_0110;
    logic [7:0] cnt_1001;
    logic       led_0110;
    logic       led_1001;
    logic       overflow;
    logic [1:0] stretch_state;

    seq_hit_logger_if #(.TS_W(8), .DEPTH(8)) ev ();

    seq_hit_logger #(
        .CNT_W    (8),
        .TS_W     (8),
        .DEPTH    (8),
        .HOLD_CYC (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hit_0110      (hit_0110),
        .hit_1001      (hit_1001),
        .clr           (clr),
        .cnt_0110      (cnt_0110),
        .cnt_1001      (cnt_1001),
        .led_0110      (led_0110),
        .led_1001      (led_1001),
        .overflow      (overflow),
        .stretch_state (stretch_state),
        .ev            (ev)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [9:0] exp_q[$];
    logic [7:0] ts_m;
    int         occ_m;
    logic       ovf_m;
    int         cnt0_m;
    int         cnt1_m;
    int         lr0_m;
    int         lr1_m;
    int         led0_hi;
    int         led1_hi;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        ts_m   = 8'd0;
        occ_m  = 0;
        ovf_m  = 1'b0;
        cnt0_m = 0;
        cnt1_m = 0;
        lr0_m  = 0;
        lr1_m  = 0;
    endtask

    task automatic check_state();
        check("ev_valid", 32'(ev.valid), 32'(occ_m != 0));
        check("ev_count", 32'(ev.count), 32'(occ_m));
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("cnt_0110", 32'(cnt_0110), 32'(cnt0_m));
        check("cnt_1001", 32'(cnt_1001), 32'(cnt1_m));
        check("led_0110", 32'(led_0110), 32'(lr0_m != 0));
        check("led_1001", 32'(led_1001), 32'(lr1_m != 0));
        check("stretch_state", 32'(stretch_state), 32'({lr1_m != 0, lr0_m != 0}));
        if (led_0110) led0_hi++;
        if (led_1001) led1_hi++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(ev.valid), 32'd0);
        check({tag, "_count"}, 32'(ev.count), 32'd0);
        check({tag, "_cnt0"}, 32'(cnt_0110), 32'd0);
        check({tag, "_cnt1"}, 32'(cnt_1001), 32'd0);
        check({tag, "_leds"}, 32'({led_1001, led_0110}), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    // One clock cycle: drive inputs, advance the model, then check at negedge.
    task automatic cycle(input logic h0, input logic h1, input logic c, input logic r);
        logic pop_m;
        logic push_m;
        logic full_m;
        hit_0110 = h0;
        hit_1001 = h1;
        clr      = c;
        ev.ready = r;
        pop_m  = (occ_m != 0) && r;
        push_m = (h0 || h1) && !c;
        full_m = (occ_m == 8);
        if (pop_m) check("head", 32'(ev.data), 32'(exp_q[0]));
        @(posedge clk);
        if (c) begin
            reset_model();
        end else begin
            if (pop_m) begin
                void'(exp_q.pop_front());
                occ_m--;
            end
            if (push_m) begin
                if (full_m && !pop_m) begin
                    ovf_m = 1'b1;
                end else begin
                    exp_q.push_back({h1, h0, ts_m});
                    occ_m++;
                end
            end
            if (h0 && cnt0_m != 255) cnt0_m++;
            if (h1 && cnt1_m != 255) cnt1_m++;
            lr0_m = h0 ? 3 : ((lr0_m > 0) ? lr0_m - 1 : 0);
            lr1_m = h1 ? 3 : ((lr1_m > 0) ? lr1_m - 1 : 0);
            ts_m  = ts_m + 8'd1;
        end
        @(negedge clk);
        hit_0110 = 1'b0;
        hit_1001 = 1'b0;
        clr      = 1'b0;
        check_state();
    endtask

    task automatic wait_ts(input logic [7:0] t, input logic r);
        for (int k = 0; k < 300 && ts_m != t; k++) cycle(1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && occ_m > 0; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("drain_empty", 32'(ev.valid), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        hit_0110 = 1'b0;
        hit_1001 = 1'b0;
        clr      = 1'b0;
        ev.ready = 1'b0;
        led0_hi  = 0;
        led1_hi  = 0;
        reset_model();

        // power-on reset
        repeat (3) @(negedge clk);
        check_all_zero("por");
        reset = 1'b1;
        check_state();

        // T2: single hits at ts=5 and ts=9 with ready high
        led0_hi = 0;
        led1_hi = 0;
        wait_ts(8'd5, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t2_ev_0110", 32'(ev.data), 32'h105);
        wait_ts(8'd9, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("t2_ev_1001", 32'(ev.data), 32'h209);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_cnt0", 32'(cnt_0110), 32'd1);
        check("t2_cnt1", 32'(cnt_1001), 32'd1);
        check("t2_led0_len", 32'(led0_hi), 32'd3);
        check("t2_led1_len", 32'(led1_hi), 32'd3);

        // T1: async reset with three entries queued
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("t1_queued", 32'(ev.count), 32'd3);
        #2 reset = 1'b0;
        #1 check_all_zero("t1_rst");
        reset_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_ts_zero", 32'(ev.data), 32'h100);
        drain();

        // T3: overflow with ready low, then in-order drain
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_count", 32'(ev.count), 32'd8);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_cnt0", 32'(cnt_0110), 32'd10);
        for (int i = 0; i < 8; i++) begin
            check("t3_order", 32'(ev.data), 32'h100 + 32'(i));
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("t3_empty", 32'(ev.valid), 32'd0);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // T4: push and pop together while full
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("t4_count", 32'(ev.count), 32'd8);
        check("t4_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            check("t4_order", 32'(ev.data), 32'h200 + 32'(i));
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("t4_empty", 32'(ev.valid), 32'd0);

        // T5: simultaneous hits and retrigger
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        wait_ts(8'd20, 1'b0);
        led0_hi = 0;
        led1_hi = 0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_both", 32'(ev.data), 32'h314);
        check("t5_one_entry", 32'(ev.count), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_led0_len", 32'(led0_hi), 32'd5);
        check("t5_led1_len", 32'(led1_hi), 32'd3);
        drain();

        // T6: counter saturation, timestamp wrap, clr against a hit
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 260; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t6_sat", 32'(cnt_0110), 32'd255);
        drain();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        wait_ts(8'd255, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_ts_ff", 32'(ev.data), 32'h2ff);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_ts_00", 32'(ev.data), 32'h200);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_ovf_set", 32'(overflow), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_all_zero("t6_clr");
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_after_clr", 32'(ev.data), 32'h100);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
